// File: rtl/fir_seq_mac.sv
// rtl/fir_seq_mac.sv - time-multiplexed FIR filter with one shared signed MAC
//
// Computes y[t] = sum_{n=0..N} K[n]*x[t-n] by evaluating one tap per cycle.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   s_valid  / s_ready / s_data   sample input handshake (signed W_X)
//   k_we     / k_addr  / k_data   coefficient write port (signed W_K, IDLE only)
//   clr      clears the sample history (IDLE only)
//   m_valid  / m_ready / m_data   result output handshake (signed W_Y)
//   busy     high whenever the FSM is not idle
module fir_seq_mac #(
    parameter  int N   = 5,
    parameter  int W_X = 8,
    parameter  int W_K = 3,
    localparam int W_A = $clog2(N + 1),
    localparam int W_Y = W_X + W_K + $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [W_X-1:0] s_data,
    input  logic                  k_we,
    input  logic        [W_A-1:0] k_addr,
    input  logic signed [W_K-1:0] k_data,
    input  logic                  clr,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic signed [W_Y-1:0] m_data,
    output logic                  busy
);

    localparam logic [W_A-1:0] LAST = W_A'(N);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [W_X-1:0] z [0:N];
    logic signed [W_K-1:0] k [0:N];
    logic signed [W_Y-1:0] acc;
    logic        [W_A-1:0] idx;

    logic signed [W_X-1:0] z_sel;
    logic signed [W_K-1:0] k_sel;
    logic signed [W_Y-1:0] prod;
    logic signed [W_Y-1:0] acc_sum;
    logic                  accept;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake decode; outputs depend on state only
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) begin
                    state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                if (idx == LAST) begin
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign accept = s_valid && (state == ST_IDLE);

    // Tap select for the shared multiplier
    always_comb begin
        z_sel = '0;
        k_sel = '0;
        for (int i = 0; i <= N; i++) begin
            if (idx == W_A'(i)) begin
                z_sel = z[i];
                k_sel = k[i];
            end
        end
    end

    // Operands are sign-extended to the full accumulator width, so the
    // product and the running sum can never wrap.
    assign prod    = W_Y'(z_sel) * W_Y'(k_sel);
    assign acc_sum = acc + prod;

    // Datapath: history, coefficient bank, accumulator, result register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n <= N; n++) begin
                z[n] <= '0;
                k[n] <= '0;
            end
            acc    <= '0;
            idx    <= '0;
            m_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (k_we && (k_addr <= LAST)) begin
                        k[k_addr] <= k_data;
                    end
                    if (accept) begin
                        // clr with an accepted sample leaves only the new sample
                        z[0] <= s_data;
                        for (int n = 1; n <= N; n++) begin
                            z[n] <= clr ? '0 : z[n-1];
                        end
                        acc <= '0;
                        idx <= '0;
                    end else if (clr) begin
                        for (int n = 0; n <= N; n++) begin
                            z[n] <= '0;
                        end
                    end
                end
                ST_MAC: begin
                    acc <= acc_sum;
                    if (idx == LAST) begin
                        m_data <= acc_sum;
                        idx    <= '0;
                    end else begin
                        idx <= idx + W_A'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_seq_mac.sv
// tb/tb_fir_seq_mac.sv - directed self-checking bench for fir_seq_mac
module tb_fir_seq_mac;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic               s_ready;
    logic signed [7:0]  s_data;
    logic               k_we;
    logic        [2:0]  k_addr;
    logic signed [2:0]  k_data;
    logic               clr;
    logic               m_valid;
    logic               m_ready;
    logic signed [13:0] m_data;
    logic               busy;

    int vectors    = 0;
    int miscompares = 0;

    int kimp [0:5] = '{1, 2, 3, -1, -2, -4};

    fir_seq_mac dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .k_we    (k_we),
        .k_addr  (k_addr),
        .k_data  (k_data),
        .clr     (clr),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_k(input int a, input int d);
        k_we   = 1'b1;
        k_addr = 3'(a);
        k_data = 3'(d);
        step();
        k_we   = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    // Accept one sample and wait for its result with m_ready high.
    // lat counts cycles from accept (cycle 0) to first m_valid.
    task automatic push(input int x, output int lat, output logic signed [13:0] y,
                        output int rdy_seen);
        s_valid = 1'b1;
        s_data  = 8'(x);
        step();
        s_valid  = 1'b0;
        lat      = 1;
        rdy_seen = 0;
        while (m_valid !== 1'b1 && lat < 50) begin
            if (s_ready === 1'b1) rdy_seen++;
            step();
            lat++;
        end
        y = m_data;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; k_we = 1'b0; k_addr = '0;
        k_data = '0; clr = 1'b0; m_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        vectors++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0 || m_data !== 14'sd0) begin
            miscompares++;
            $display("FAIL reset: s_ready=%b m_valid=%b busy=%b m_data=%0d, want 1 0 0 0",
                     s_ready, m_valid, busy, m_data);
        end
    endtask

    task automatic test_impulse();
        int lat; int rdy; logic signed [13:0] y;
        for (int i = 0; i < 6; i++) write_k(i, kimp[i]);
        pulse_clr();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (s_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL impulse_sready[%0d]: got %b want 1", i, s_ready);
            end
            push((i == 0) ? 1 : 0, lat, y, rdy);
            vectors++;
            if (y !== 14'(kimp[i])) begin
                miscompares++;
                $display("FAIL impulse_data[%0d]: got %0d want %0d", i, y, kimp[i]);
            end
            vectors++;
            if (lat != 7 || rdy != 0) begin
                miscompares++;
                $display("FAIL impulse_timing[%0d]: latency %0d sready_highs %0d want 7 0",
                         i, lat, rdy);
            end
        end
    endtask

    task automatic test_step();
        int lat; int rdy; logic signed [13:0] y;
        int exp_y [0:5] = '{10, 30, 60, 50, 30, -10};
        pulse_clr();
        for (int i = 0; i < 6; i++) begin
            push(10, lat, y, rdy);
            vectors++;
            if (y !== 14'(exp_y[i])) begin
                miscompares++;
                $display("FAIL step[%0d]: got %0d want %0d", i, y, exp_y[i]);
            end
        end
    endtask

    task automatic test_extremes();
        int lat; int rdy; logic signed [13:0] y;
        int exp_p [0:5] = '{2052, 1032, 12, -1008, -2028, -3048};
        for (int i = 0; i < 6; i++) write_k(i, -4);
        pulse_clr();
        for (int i = 0; i < 6; i++) begin
            push(-128, lat, y, rdy);
            vectors++;
            if (y !== 14'(512 * (i + 1))) begin
                miscompares++;
                $display("FAIL extreme_neg[%0d]: got %0d want %0d", i, y, 512 * (i + 1));
            end
        end
        for (int i = 0; i < 6; i++) begin
            push(127, lat, y, rdy);
            vectors++;
            if (y !== 14'(exp_p[i])) begin
                miscompares++;
                $display("FAIL extreme_pos[%0d]: got %0d want %0d", i, y, exp_p[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat; int rdy; int n; logic signed [13:0] y;
        for (int i = 0; i < 6; i++) write_k(i, kimp[i]);
        pulse_clr();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'sd5;
        step();
        s_valid = 1'b0;
        n = 1;
        while (m_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        vectors++;
        if (n != 7 || m_data !== 14'sd5) begin
            miscompares++;
            $display("FAIL bp_first: latency %0d data %0d want 7 5", n, m_data);
        end
        for (int c = 0; c < 5; c++) begin
            s_valid = (c % 2 == 0);
            s_data  = 8'sd99;
            step();
            vectors++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1 || m_data !== 14'sd5) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: m_valid=%b s_ready=%b busy=%b m_data=%0d want 1 0 1 5",
                         c, m_valid, s_ready, busy, m_data);
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        vectors++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: m_valid=%b s_ready=%b busy=%b want 0 1 0",
                     m_valid, s_ready, busy);
        end
        // z[1] must hold 5, not 99: K1*5 = 10
        push(0, lat, y, rdy);
        vectors++;
        if (y !== 14'sd10) begin
            miscompares++;
            $display("FAIL bp_not_absorbed: got %0d want 10", y);
        end
    endtask

    task automatic test_write_protect_clear();
        int lat; int rdy; int n; logic signed [13:0] y;
        pulse_clr();
        s_valid = 1'b1;
        s_data  = 8'sd1;
        step();
        s_valid = 1'b0;
        write_k(0, 3);
        write_k(7, 1);
        n = 3;
        while (m_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        vectors++;
        if (m_data !== 14'sd1 || n != 7) begin
            miscompares++;
            $display("FAIL wp_k0: got %0d latency %0d want 1 7", m_data, n);
        end
        step();
        for (int i = 1; i < 6; i++) begin
            push(0, lat, y, rdy);
            vectors++;
            if (y !== 14'(kimp[i])) begin
                miscompares++;
                $display("FAIL wp_impulse[%0d]: got %0d want %0d", i, y, kimp[i]);
            end
        end
        // Coefficient write and sample accept in the same IDLE cycle
        pulse_clr();
        k_we = 1'b1; k_addr = 3'd0; k_data = 3'sd2;
        push(3, lat, y, rdy);
        k_we = 1'b0;
        vectors++;
        if (y !== 14'sd6) begin
            miscompares++;
            $display("FAIL write_with_accept: got %0d want 6", y);
        end
        write_k(0, 1);
        // clr with an accepted sample drops the stored 3 from z[1]
        clr = 1'b1;
        push(1, lat, y, rdy);
        clr = 1'b0;
        vectors++;
        if (y !== 14'sd1) begin
            miscompares++;
            $display("FAIL clr_with_accept: got %0d want 1", y);
        end
    endtask

    task automatic test_reset_mid_mac();
        int lat; int rdy; logic signed [13:0] y;
        pulse_clr();
        s_valid = 1'b1;
        s_data  = 8'sd7;
        step();
        s_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0 || m_data !== 14'sd0) begin
            miscompares++;
            $display("FAIL rst_mid_mac: m_valid=%b s_ready=%b busy=%b m_data=%0d want 0 1 0 0",
                     m_valid, s_ready, busy, m_data);
        end
        for (int i = 0; i < 6; i++) begin
            push((i == 0) ? 1 : 0, lat, y, rdy);
            vectors++;
            if (y !== 14'sd0 || lat != 7) begin
                miscompares++;
                $display("FAIL rst_coeffs_zero[%0d]: got %0d latency %0d want 0 7", i, y, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_step();
        test_extremes();
        test_backpressure();
        test_write_protect_clear();
        test_reset_mid_mac();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
